// File: rtl/stp16_chain_driver_if.sv
// Frame handshake between the level-meter frame builder and the STP16 chain driver.
interface stp16_chain_driver_if #(
   parameter int W           = 32,
   parameter int BRIGHT_BITS = 4
);
   logic                   i_valid;
   logic                   i_ready;
   logic [W-1:0]           data;
   logic [BRIGHT_BITS-1:0] brightness;

   modport master (output i_valid, data, brightness, input i_ready);
   modport slave  (input i_valid, data, brightness, output i_ready);
endinterface

// File: rtl/stp16_chain_driver.sv
// Serial driver for a daisy-chain of STP16CPC26 LED sinks: shifts one frame per
// handshake, pulses LE, and uses NOE as a global PWM brightness control.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | ready for a frame, serial clock and LE low
// ST_SHIFT | shifting W bits, CLK_DIV cycles low then CLK_DIV cycles high
// ST_LATCH | LE high for CLK_DIV cycles, brightness follows the new frame
module stp16_chain_driver #(
   parameter int CHAIN       = 2,
   parameter int CLK_DIV     = 2,
   parameter int MSB_FIRST   = 1,
   parameter int BRIGHT_BITS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   stp16_chain_driver_if.slave  frame_if,
   output logic                 stp16_le,
   output logic                 stp16_noe,
   output logic                 stp16_clk,
   output logic                 stp16_sdi
);
   localparam int W  = 16 * CHAIN;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(W);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH} state_t;

   state_t                 state_q, state_d;
   logic [W-1:0]           shreg_q, shreg_d;
   logic [DW-1:0]          div_q, div_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic                   phase_q, phase_d;
   logic [BRIGHT_BITS-1:0] bright_q, bright_d;
   logic [BRIGHT_BITS-1:0] bright_act_q, bright_act_d;
   logic [BRIGHT_BITS-1:0] pwm_q;
   logic                   shown_q, shown_d;
   logic                   ready_q, ready_d;
   logic                   le_q, le_d;
   logic                   sclk_q, sclk_d;
   logic                   sdi_q, sdi_d;
   logic                   noe_q, noe_d;
   logic                   div_tc;

   function automatic logic head_bit(input logic [W-1:0] v);
      return (MSB_FIRST != 0) ? v[W-1] : v[0];
   endfunction

   function automatic logic [W-1:0] advance(input logic [W-1:0] v);
      return (MSB_FIRST != 0) ? {v[W-2:0], 1'b0} : {1'b0, v[W-1:1]};
   endfunction

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      div_d        = div_q;
      bit_d        = bit_q;
      phase_d      = phase_q;
      bright_d     = bright_q;
      bright_act_d = bright_act_q;
      shown_d      = shown_q;
      ready_d      = ready_q;
      le_d         = le_q;
      sclk_d       = sclk_q;
      sdi_d        = sdi_q;
      div_tc       = (div_q == '0);

      case (state_q)
         ST_IDLE: begin
            ready_d = 1'b1;
            le_d    = 1'b0;
            sclk_d  = 1'b0;
            if (frame_if.i_valid && ready_q) begin
               state_d  = ST_SHIFT;
               ready_d  = 1'b0;
               shreg_d  = frame_if.data;
               sdi_d    = head_bit(frame_if.data);
               bright_d = frame_if.brightness;
               div_d    = DIV_LAST;
               bit_d    = '0;
               phase_d  = 1'b0;
            end
         end
         ST_SHIFT: begin
            div_d = div_q - 1'b1;
            if (div_tc) begin
               div_d = DIV_LAST;
               if (!phase_q) begin
                  phase_d = 1'b1;
                  sclk_d  = 1'b1;
               end else begin
                  // falling transition: the only point where the bit advances
                  phase_d = 1'b0;
                  sclk_d  = 1'b0;
                  if (bit_q == BIT_LAST) begin
                     state_d = ST_LATCH;
                     le_d    = 1'b1;
                  end else begin
                     bit_d   = bit_q + 1'b1;
                     shreg_d = advance(shreg_q);
                     sdi_d   = head_bit(advance(shreg_q));
                  end
               end
            end
         end
         ST_LATCH: begin
            div_d = div_q - 1'b1;
            if (div_tc) begin
               state_d      = ST_IDLE;
               le_d         = 1'b0;
               ready_d      = 1'b1;
               shown_d      = 1'b1;
               bright_act_d = bright_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      noe_d = !(shown_q && (pwm_q < bright_act_q));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         shreg_q      <= '0;
         div_q        <= '0;
         bit_q        <= '0;
         phase_q      <= 1'b0;
         bright_q     <= '0;
         bright_act_q <= '0;
         pwm_q        <= '0;
         shown_q      <= 1'b0;
         ready_q      <= 1'b0;
         le_q         <= 1'b0;
         sclk_q       <= 1'b0;
         sdi_q        <= 1'b0;
         noe_q        <= 1'b1;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         div_q        <= div_d;
         bit_q        <= bit_d;
         phase_q      <= phase_d;
         bright_q     <= bright_d;
         bright_act_q <= bright_act_d;
         pwm_q        <= pwm_q + 1'b1;
         shown_q      <= shown_d;
         ready_q      <= ready_d;
         le_q         <= le_d;
         sclk_q       <= sclk_d;
         sdi_q        <= sdi_d;
         noe_q        <= noe_d;
      end
   end

   assign frame_if.i_ready = ready_q;
   assign stp16_le         = le_q;
   assign stp16_noe        = noe_q;
   assign stp16_clk        = sclk_q;
   assign stp16_sdi        = sdi_q;
endmodule

// File: tb/tb_stp16_chain_driver.sv
// Bench for stp16_chain_driver: three configurations, frames scoreboarded
// against the bit stream sampled on each stp16_clk rise.
module tb_stp16_chain_driver;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc++;

   localparam int W_OF   [3] = '{32, 32, 48};
   localparam int DIV_OF [3] = '{2, 2, 1};
   localparam int MSB_OF [3] = '{1, 0, 1};

   stp16_chain_driver_if #(.W(32), .BRIGHT_BITS(4)) bus_a ();
   stp16_chain_driver_if #(.W(32), .BRIGHT_BITS(4)) bus_b ();
   stp16_chain_driver_if #(.W(48), .BRIGHT_BITS(4)) bus_c ();

   logic [2:0] sclk, sdi, le, noe, rdy;
   assign rdy[0] = bus_a.i_ready;
   assign rdy[1] = bus_b.i_ready;
   assign rdy[2] = bus_c.i_ready;

   stp16_chain_driver #(.CHAIN(2), .CLK_DIV(2), .MSB_FIRST(1), .BRIGHT_BITS(4)) dut_a (
      .clk(clk), .reset(reset), .frame_if(bus_a),
      .stp16_le(le[0]), .stp16_noe(noe[0]), .stp16_clk(sclk[0]), .stp16_sdi(sdi[0]));
   stp16_chain_driver #(.CHAIN(2), .CLK_DIV(2), .MSB_FIRST(0), .BRIGHT_BITS(4)) dut_b (
      .clk(clk), .reset(reset), .frame_if(bus_b),
      .stp16_le(le[1]), .stp16_noe(noe[1]), .stp16_clk(sclk[1]), .stp16_sdi(sdi[1]));
   stp16_chain_driver #(.CHAIN(3), .CLK_DIV(1), .MSB_FIRST(1), .BRIGHT_BITS(4)) dut_c (
      .clk(clk), .reset(reset), .frame_if(bus_c),
      .stp16_le(le[2]), .stp16_noe(noe[2]), .stp16_clk(sclk[2]), .stp16_sdi(sdi[2]));

   typedef struct {
      int          dut;
      logic [47:0] frame;
      int          t0;
   } exp_t;
   exp_t sb_q[$];

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // monitor state, one slot per DUT
   logic [47:0] acc [3];
   int   rises [3], le_w [3], sclk_in_le [3], noe_low [3], last_rdy [3], last_t0 [3];
   logic pend [3], first_bit [3], sclk_p [3], le_p [3], rdy_p [3];

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            acc[i] = '0; rises[i] = 0; le_w[i] = 0; sclk_in_le[i] = 0; pend[i] = 1'b0;
         end else begin
            if (sclk[i] && !sclk_p[i]) begin
               if (rises[i] == 0) begin
                  first_bit[i] = sdi[i];
                  if (sb_q.size() > 0 && sb_q[0].dut == i)
                     chk_eq($sformatf("d%0d_first_rise", i), cyc - sb_q[0].t0, DIV_OF[i]);
               end
               if (rises[i] < W_OF[i]) begin
                  if (MSB_OF[i] != 0) acc[i][W_OF[i]-1-rises[i]] = sdi[i];
                  else                acc[i][rises[i]] = sdi[i];
               end
               rises[i]++;
            end
            if (sclk[i] && le[i]) sclk_in_le[i]++;
            if (le[i]) le_w[i]++;
            if (le[i] && !le_p[i]) begin
               if (sb_q.size() == 0) chk_eq($sformatf("d%0d_unexpected_le", i), 1, 0);
               else begin
                  exp_t e;
                  e = sb_q.pop_front();
                  chk_eq($sformatf("d%0d_sb_dut", i), i, e.dut);
                  chk_eq($sformatf("d%0d_frame", i), acc[i], e.frame);
                  chk_eq($sformatf("d%0d_rises", i), rises[i], W_OF[i]);
                  chk_eq($sformatf("d%0d_le_start", i), cyc - e.t0, 2 * W_OF[i] * DIV_OF[i]);
                  last_t0[i] = e.t0;
                  pend[i]    = 1'b1;
               end
            end
            if (!le[i] && le_p[i]) begin
               chk_eq($sformatf("d%0d_le_width", i), le_w[i], DIV_OF[i]);
               chk_eq($sformatf("d%0d_sclk_in_le", i), sclk_in_le[i], 0);
               acc[i] = '0; rises[i] = 0; le_w[i] = 0; sclk_in_le[i] = 0;
            end
            if (rdy[i] && !rdy_p[i]) begin
               last_rdy[i] = cyc;
               if (pend[i])
                  chk_eq($sformatf("d%0d_ready_latency", i), cyc - last_t0[i],
                         (2 * W_OF[i] + 1) * DIV_OF[i]);
               pend[i] = 1'b0;
            end
            if (!noe[i]) noe_low[i]++;
         end
         sclk_p[i] = sclk[i];
         le_p[i]   = le[i];
         rdy_p[i]  = rdy[i];
      end
   end

   task automatic drive(input int i, input logic v, input logic [47:0] d, input logic [3:0] b);
      case (i)
         0: begin bus_a.i_valid = v; bus_a.data = d[31:0]; bus_a.brightness = b; end
         1: begin bus_b.i_valid = v; bus_b.data = d[31:0]; bus_b.brightness = b; end
         default: begin bus_c.i_valid = v; bus_c.data = d; bus_c.brightness = b; end
      endcase
   endtask

   task automatic send(input int i, input logic [47:0] d, input logic [3:0] b,
                       input bit hold, input bit push, output int t0);
      int n = 0;
      @(negedge clk);
      drive(i, 1'b1, d, b);
      while (!rdy[i] && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!rdy[i]) begin
         chk_eq($sformatf("d%0d_handshake_timeout", i), 0, 1);
         drive(i, 1'b0, d, b);
         t0 = 0;
         return;
      end
      @(posedge clk);
      #1;
      t0 = cyc;
      if (push) sb_q.push_back('{dut: i, frame: d, t0: cyc});
      if (!hold) drive(i, 1'b0, d, b);
   endtask

   task automatic wait_idle(input int i);
      int n = 0;
      @(negedge clk);
      while (!rdy[i] && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!rdy[i]) chk_eq($sformatf("d%0d_idle_timeout", i), 0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t0b;
      for (int i = 0; i < 3; i++) drive(i, 1'b0, '0, '0);

      #1 reset = 1'b1;
      #1;
      chk_eq("rst_ready", rdy[0], 0);
      chk_eq("rst_le", le[0], 0);
      chk_eq("rst_noe", noe[0], 1);
      chk_eq("rst_sclk", sclk[0], 0);
      chk_eq("rst_sdi", sdi[0], 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1 chk_eq("ready_before_edge", rdy[0], 0);
      @(posedge clk);
      #1 chk_eq("ready_after_reset", rdy[0], 1);

      // brightness 0 keeps the first frame dark
      noe_low[0] = 0;
      send(0, 48'h0000_C3C3_3C3C, 4'h0, 1'b0, 1'b1, t0);
      wait_idle(0);
      repeat (16) @(posedge clk);
      #1 chk_eq("noe_dark_b0", noe_low[0], 0);

      // brightness 8 takes effect only once its frame latches
      noe_low[0] = 0;
      send(0, 48'h0000_0F0F_F0F0, 4'h8, 1'b0, 1'b1, t0);
      wait_idle(0);
      @(posedge clk);
      #1 chk_eq("noe_dark_until_latch", noe_low[0], 0);
      noe_low[0] = 0;
      repeat (16) @(posedge clk);
      #1 chk_eq("noe_duty_b8", noe_low[0], 8);

      send(0, 48'h0000_1234_5678, 4'hF, 1'b0, 1'b1, t0);
      wait_idle(0);
      @(posedge clk);
      #1 noe_low[0] = 0;
      repeat (16) @(posedge clk);
      #1 chk_eq("noe_duty_bF", noe_low[0], 15);

      // back-to-back with i_valid held high
      send(0, 48'h0000_5555_5555, 4'hF, 1'b1, 1'b1, t0);
      send(0, 48'h0000_1111_1111, 4'hF, 1'b0, 1'b1, t0b);
      chk_eq("b2b_gap", t0b - last_rdy[0], 1);
      chk_eq("b2b_period", t0b - t0, 131);
      wait_idle(0);

      // LSB-first configuration
      send(1, 48'h0000_0000_0001, 4'hF, 1'b0, 1'b1, t0);
      wait_idle(1);
      chk_eq("lsb_first_bit", first_bit[1], 1);
      send(1, 48'h0000_DEAD_BEEF, 4'h3, 1'b0, 1'b1, t0);
      wait_idle(1);

      // three-chip chain, CLK_DIV=1
      send(2, 48'hA5A5_0000_FFFF, 4'hF, 1'b0, 1'b1, t0);
      wait_idle(2);
      send(2, 48'h8000_0001_7E7E, 4'h1, 1'b0, 1'b1, t0);
      wait_idle(2);

      // reset in the middle of a frame
      send(0, 48'h0000_FFFF_0000, 4'hF, 1'b0, 1'b0, t0);
      begin
         int n = 0;
         while (rises[0] < 10 && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (rises[0] < 10) chk_eq("mid_reset_reach_bit10", rises[0], 10);
      end
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk_eq("mid_rst_ready", rdy[0], 0);
      chk_eq("mid_rst_le", le[0], 0);
      chk_eq("mid_rst_noe", noe[0], 1);
      chk_eq("mid_rst_sclk", sclk[0], 0);
      chk_eq("mid_rst_sdi", sdi[0], 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1 chk_eq("mid_rst_ready_hold", rdy[0], 0);
      @(posedge clk);
      #1 chk_eq("mid_rst_ready_recover", rdy[0], 1);
      noe_low[0] = 0;
      repeat (100) @(posedge clk);
      #1 chk_eq("mid_rst_noe_blank", noe_low[0], 0);

      chk_eq("scoreboard_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/stp16_chain_driver.md
# stp16_chain_driver

Parametrised serial driver for a daisy-chain of STP16CPC26 16-bit constant-current LED sinks. It accepts one full-chain frame per valid/ready handshake, shifts it out MSB- or LSB-first with a programmable serial clock rate, pulses the latch, and drives `stp16_noe` as a global PWM brightness control. It sits between the level-meter frame builder and the board pins, and replaces the fixed 32-bit, fixed-rate driver.

## Interface
- `CHAIN`, 2: number of cascaded 16-bit drivers; frame width `W = 16*CHAIN`, minimum 1.
- `CLK_DIV`, 2: `clk` cycles per `stp16_clk` half-period; also the LE pulse width; minimum 1.
- `MSB_FIRST`, 1: 1 = `data[W-1]` shifted first; 0 = `data[0]` first.
- `BRIGHT_BITS`, 4: width of the brightness control and PWM counter.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  frame offered.
- `i_ready`  out  1  block idle and able to accept a frame.
- `data`  in  W  frame; the bit that reaches the far end of the chain is shifted first.
- `brightness`  in  BRIGHT_BITS  on-time in PWM slots; captured with `data`.
- `stp16_le`  out  1  latch enable, active-high.
- `stp16_noe`  out  1  output enable, active-low.
- `stp16_clk`  out  1  serial clock; the driver samples on its rising edge.
- `stp16_sdi`  out  1  serial data.

## Operation
- States: IDLE, SHIFT, LATCH.
- IDLE: `i_ready`=1, `stp16_clk`=0, `stp16_le`=0. On `i_valid && i_ready` at a rising edge, capture `data` into the shift register and `brightness` into `bright_q`, clear the bit and divider counters, and go to SHIFT. `i_ready` drops on the same edge.
- SHIFT: each bit occupies `2*CLK_DIV` cycles. For the first `CLK_DIV` cycles, `stp16_clk`=0 and `stp16_sdi` holds the bit. For the next `CLK_DIV` cycles, `stp16_clk`=1 and `stp16_sdi` is unchanged. The register advances only on the falling transition. After bit `W-1` completes, go to LATCH.
- LATCH: `stp16_le`=1 and `stp16_clk`=0 for `CLK_DIV` cycles, then go to IDLE.
- PWM: a free-running `BRIGHT_BITS` counter `pwm` increments every `clk` and wraps at 2^BRIGHT_BITS−1 → 0. `stp16_noe` = !(frame_shown && pwm < bright_q_active).
  - `bright_q_active` takes the value of `bright_q` on the LATCH→IDLE edge, so brightness changes together with the displayed frame.
  - `frame_shown` sets on the first LATCH→IDLE edge after reset.
  - brightness 0 → permanently dark. All-ones → lit (2^B−1) of every 2^B cycles.
- `i_valid` outside IDLE is ignored. `data` and `brightness` need to be stable only in the handshake cycle.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is abandoned with no LE pulse, and the driver keeps its previous latched contents, blanked by `stp16_noe`=1.

## Timing
- Reset values:
  - `i_ready`=0, `stp16_le`=0, `stp16_noe`=1, `stp16_clk`=0, `stp16_sdi`=0.
  - state IDLE, `pwm`=0, `frame_shown`=0, `bright_q`=0, `bright_q_active`=0.
- `i_ready` rises at the first rising edge after `reset` deasserts.
- All outputs are registered, with no combinational path from inputs to outputs.
- With the handshake at edge T0:
  - first `stp16_sdi` bit is valid after T0.
  - the k-th `stp16_clk` rise (k=0..W−1) occurs at T0 + (2k+1)·CLK_DIV.
  - LE is high from T0 + 2W·CLK_DIV to T0 + (2W+1)·CLK_DIV.
  - `i_ready`=1 again at T0 + (2W+1)·CLK_DIV. A new handshake is accepted on the next edge.
- Sustained throughput is one frame per (2W+1)·CLK_DIV + 1 cycles.
- `stp16_sdi` setup and hold around the `stp16_clk` rise are each CLK_DIV cycles.

## Test plan
- Reset, CHAIN=2, CLK_DIV=2, MSB_FIRST=1, data=32'h12345678, brightness=4'hF:
  - 32 `stp16_clk` rises, with sampled bits forming 0x12345678.
  - LE high exactly 2 cycles.
  - `i_ready` returns 130 cycles after the handshake.
  - `stp16_noe` is low 15 of every 16 cycles afterwards.
- MSB_FIRST=0, data=32'h00000001: the first sampled bit is 1 and the remaining 31 are 0.
- Back-to-back frames 32'h55555555 then 32'h11111111, with `i_valid` held high:
  - second handshake on the edge after `i_ready` rises.
  - sampled streams match both frames.
  - no `stp16_clk` pulse occurs during LE.
- brightness=0, then 4'h8: `stp16_noe` stays 1 for the first frame, then is low exactly 8 of 16 cycles only after the second latch.
- `reset` asserted at bit 10 of a frame: outputs go to reset values without a clock, no LE pulse occurs, and `i_ready` recovers one cycle after release.
- CHAIN=3, CLK_DIV=1, data=48'hA5A5_0000_FFFF: 48 rises, 1-cycle LE, and `i_ready` returns after 97 cycles.
